// File: rtl/tx_link_arbiter.sv
// Round-robin arbiter sharing one serial link among N_REQ byte sources.
// Frames are 11 bit-cycles: start, 8 data bits LSB first, parity, stop.
module tx_link_arbiter #(
    parameter int N_REQ      = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                     baud_clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data_in,
    input  logic                     rx_ready,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] cur_src,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     data_out
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cur_src_q;
    logic [N_REQ-1:0] grant_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             data_out_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] ptr_d;
    logic [N_REQ-1:0] grant_d;
    logic [7:0]       win_byte;
    logic             parity_bit;

    // Search starts at ptr_q and wraps; first pending requester wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_byte = '0;
        grant_d  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_byte   = data_in[8*i +: 8];
                grant_d[i] = 1'b1;
            end
        end
        ptr_d      = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        parity_bit = (^shift_q) ^ (PARITY_ODD != 0);
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            ptr_q        <= '0;
            cur_src_q    <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= 1'b1;
        end else begin
            grant_q      <= '0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    data_out_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (win_found && rx_ready) begin
                        state_q    <= S_START;
                        shift_q    <= win_byte;
                        grant_q    <= grant_d;
                        cur_src_q  <= win_idx;
                        ptr_q      <= ptr_d;
                        data_out_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    state_q    <= S_DATA;
                    bit_idx_q  <= '0;
                    data_out_q <= shift_q[0];
                end
                S_DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        state_q    <= S_PARITY;
                        data_out_q <= parity_bit;
                    end else begin
                        bit_idx_q  <= bit_idx_q + 3'd1;
                        data_out_q <= shift_q[bit_idx_q + 3'd1];
                    end
                end
                S_PARITY: begin
                    state_q      <= S_STOP;
                    data_out_q   <= 1'b1;
                    frame_done_q <= 1'b1;
                end
                S_STOP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign cur_src    = cur_src_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_tx_link_arbiter.sv
// Directed bench for tx_link_arbiter: an even-parity and an odd-parity
// instance share all inputs so every frame is checked against both.
module tb_tx_link_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        rx_ready;

    logic [3:0]  grant_e, grant_o;
    logic [1:0]  cur_src_e, cur_src_o;
    logic        busy_e, busy_o;
    logic        frame_done_e, frame_done_o;
    logic        data_out_e, data_out_o;

    int n_checks = 0;
    int n_errs   = 0;

    tx_link_arbiter #(.N_REQ(4), .PARITY_ODD(0)) dut_e (
        .baud_clk(clk), .rst(rst), .req(req), .data_in(data_in), .rx_ready(rx_ready),
        .grant(grant_e), .cur_src(cur_src_e), .busy(busy_e),
        .frame_done(frame_done_e), .data_out(data_out_e)
    );

    tx_link_arbiter #(.N_REQ(4), .PARITY_ODD(1)) dut_o (
        .baud_clk(clk), .rst(rst), .req(req), .data_in(data_in), .rx_ready(rx_ready),
        .grant(grant_o), .cur_src(cur_src_o), .busy(busy_o),
        .frame_done(frame_done_o), .data_out(data_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int limit, output int waited);
        waited = 0;
        while (grant_e == 4'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Call at the negedge of the START cycle; returns at the negedge of STOP.
    task automatic check_frame(input string tag, input logic [7:0] b, input int drop_rx_at);
        logic [10:0] obs_e, obs_o, fd_e, bz_e;
        logic [10:0] exp_e, exp_o;
        int          extra_grants;
        exp_e = {1'b1, ^b, b, 1'b0};
        exp_o = {1'b1, ~^b, b, 1'b0};
        extra_grants = 0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            obs_e[i] = data_out_e;
            obs_o[i] = data_out_o;
            fd_e[i]  = frame_done_e;
            bz_e[i]  = busy_e;
            if (i > 0 && grant_e != 4'b0) extra_grants++;
            if (i == drop_rx_at) rx_ready = 1'b0;
        end
        check({tag, "_bits_even"}, 32'(obs_e), 32'(exp_e));
        check({tag, "_bits_odd"}, 32'(obs_o), 32'(exp_o));
        check({tag, "_frame_done"}, 32'(fd_e), 32'h400);
        check({tag, "_busy"}, 32'(bz_e), 32'h7FF);
        check({tag, "_grant_in_frame"}, 32'(extra_grants), 32'd0);
    endtask

    initial begin
        int          waited;
        int          stamp [5];
        logic [3:0]  gseen [5];
        logic [1:0]  cseen [5];
        int          ng;
        int          bad;

        rst = 1'b1;
        req = '0;
        data_in = '0;
        rx_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_data_out", 32'(data_out_e), 32'd1);
        check("rst_grant", 32'(grant_e), 32'd0);
        check("rst_busy", 32'(busy_e), 32'd0);
        check("rst_frame_done", 32'(frame_done_e), 32'd0);
        check("rst_cur_src", 32'(cur_src_e), 32'd0);

        // Single requester, byte 0xA5
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        data_in[7:0] = 8'hA5;
        rx_ready = 1'b1;
        @(negedge clk);
        check("a5_grant", 32'(grant_e), 32'h1);
        check("a5_cur_src", 32'(cur_src_e), 32'd0);
        req = 4'b0000;
        check_frame("a5", 8'hA5, -1);
        @(negedge clk);
        check("a5_grant_gone", 32'(grant_e), 32'd0);

        // All four requesting: round-robin order, 12 cycles apart
        reset_dut();
        req = 4'b1111;
        data_in = 32'h44332211;
        rx_ready = 1'b1;
        ng = 0;
        for (int c = 1; c <= 60 && ng < 5; c++) begin
            @(negedge clk);
            if (grant_e != 4'b0) begin
                stamp[ng] = c;
                gseen[ng] = grant_e;
                cseen[ng] = cur_src_e;
                ng++;
            end
        end
        req = 4'b0000;
        check("rr_grant_count", 32'(ng), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                check($sformatf("rr_grant%0d", k), 32'(gseen[k]), 32'(4'b0001 << (k % 4)));
                check($sformatf("rr_src%0d", k), 32'(cseen[k]), 32'(k % 4));
                if (k > 0) check($sformatf("rr_gap%0d", k), 32'(stamp[k] - stamp[k-1]), 32'd12);
            end
        end

        // Requester 2 blocked by rx_ready low, then granted
        reset_dut();
        req = 4'b0100;
        data_in = 32'h00960000;
        rx_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant_e != 4'b0 || data_out_e != 1'b1 || busy_e != 1'b0) bad++;
        end
        check("blocked_idle", 32'(bad), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        check("unblock_grant", 32'(grant_e), 32'h4);
        check("unblock_cur_src", 32'(cur_src_e), 32'd2);
        req = 4'b0000;
        check_frame("src2", 8'h96, -1);
        repeat (3) @(negedge clk);
        check("cur_src_hold", 32'(cur_src_e), 32'd2);
        check("idle_busy", 32'(busy_e), 32'd0);
        check("idle_line", 32'(data_out_e), 32'd1);

        // Parity edge bytes; byte swapped under the in-flight frame
        reset_dut();
        req = 4'b0001;
        data_in = 32'h0;
        rx_ready = 1'b1;
        wait_grant(5, waited);
        check("par00_grant", 32'(grant_e), 32'h1);
        data_in[7:0] = 8'hFF;
        check_frame("par00", 8'h00, -1);
        @(negedge clk);
        wait_grant(5, waited);
        check("parFF_grant", 32'(grant_e), 32'h1);
        req = 4'b0000;
        check_frame("parFF", 8'hFF, -1);

        // Reset during DATA bit 4
        reset_dut();
        req = 4'b0001;
        data_in = 32'h0000000F;
        rx_ready = 1'b1;
        wait_grant(5, waited);
        check("rstmid_grant", 32'(grant_e), 32'h1);
        req = 4'b0011;
        repeat (5) @(negedge clk);
        check("rstmid_bit4", 32'(data_out_e), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rstmid_line", 32'(data_out_e), 32'd1);
        check("rstmid_busy", 32'(busy_e), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_regrant", 32'(grant_e), 32'h1);
        req = 4'b0000;
        check_frame("rstmid", 8'h0F, -1);

        // rx_ready dropped at DATA bit 2: frame completes, next grant waits
        reset_dut();
        req = 4'b0010;
        data_in = 32'h00003C00;
        rx_ready = 1'b1;
        wait_grant(5, waited);
        check("drop_grant", 32'(grant_e), 32'h2);
        check_frame("drop", 8'h3C, 3);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (grant_e != 4'b0 || data_out_e != 1'b1) bad++;
        end
        check("drop_no_grant", 32'(bad), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        check("drop_regrant", 32'(grant_e), 32'h2);
        req = 4'b0000;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
